serial_subtractor: RTL and testbench

- Parametrised multi-cycle subtractor built from full-subtractor cells.
- Computes diff = a - b - bin over WIDTH bits, processing DIGIT bits per clock with a registered borrow between digits.
- Serves datapaths where a full-width ripple subtractor is too long for timing or too large in area.
- Start/done handshake; also reports borrow-out, zero and signed-overflow flags.

---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, resolved DIGIT bits per clock
// through a ripple of full-subtractor cells with a registered borrow between digits.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic             dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

    logic [DIGIT-1:0]       dig;
    logic                   chain_bout;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;

    // One digit of full-subtractor cells, borrow rippling from bit 0 upward.
    always_comb begin : ripple
        logic br;
        br  = br_q;
        dig = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i] = a_sh_q[i] ^ b_sh_q[i] ^ br;
            br     = (~a_sh_q[i] & b_sh_q[i]) | (~a_sh_q[i] & br) | (b_sh_q[i] & br);
        end
        chain_bout = br;
    end

    // Digit enters the result register from the top; the wide concat keeps
    // the shift legal even when DIGIT equals WIDTH.
    always_comb begin
        res_cat  = {dig, res_q} >> DIGIT;
        res_next = res_cat[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> DIGIT;
                b_sh_d = b_sh_q >> DIGIT;
                res_d  = res_next;
                br_d   = chain_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = res_next;
                    bout_d  = chain_bout;
                    zero_d  = (res_next == '0);
                    // Operand signs were captured at start since the shifters lose them.
                    ovf_d   = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed checks on WIDTH=16/DIGIT=4 and a random
// sweep over four parameterisations against an arithmetic reference model.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        bin_in = 1'b0;

    // Instances: 0 W16/D1, 1 W16/D4, 2 W16/D16, 3 W8/D2
    logic [15:0] diff_o [4];
    logic        busy_o [4];
    logic        done_o [4];
    logic        bout_o [4];
    logic        zero_o [4];
    logic        ovf_o  [4];
    logic        st_o   [4];
    logic [7:0]  diff8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy_o[0]), .done(done_o[0]), .diff(diff_o[0]), .bout(bout_o[0]),
        .zero(zero_o[0]), .ovf(ovf_o[0]), .dbg_state(st_o[0]));
    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy_o[1]), .done(done_o[1]), .diff(diff_o[1]), .bout(bout_o[1]),
        .zero(zero_o[1]), .ovf(ovf_o[1]), .dbg_state(st_o[1]));
    serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy_o[2]), .done(done_o[2]), .diff(diff_o[2]), .bout(bout_o[2]),
        .zero(zero_o[2]), .ovf(ovf_o[2]), .dbg_state(st_o[2]));
    serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_w8 (
        .clk(clk), .rst(rst), .start(start), .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
        .busy(busy_o[3]), .done(done_o[3]), .diff(diff8), .bout(bout_o[3]),
        .zero(zero_o[3]), .ovf(ovf_o[3]), .dbg_state(st_o[3]));
    assign diff_o[3] = {8'h00, diff8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction; ovf follows the sign rule on latched operands.
    task automatic model(input int w, input int a, input int b, input int bi,
                         output int d, output int bo, output int z, output int o);
        longint mask, aa, bb, r;
        int     sa, sb, sd;
        mask = (64'd1 << w) - 1;
        aa   = a & mask;
        bb   = b & mask;
        r    = aa - bb - bi;
        bo   = (r < 0) ? 1 : 0;
        d    = int'(r & mask);
        z    = (d == 0) ? 1 : 0;
        sa   = int'((aa >> (w - 1)) & 1);
        sb   = int'((bb >> (w - 1)) & 1);
        sd   = (d >> (w - 1)) & 1;
        o    = ((sa != sb) && (sd != sa)) ? 1 : 0;
    endtask

    // Called just after a clock edge; checks the DIGIT=4 instance end to end.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [15:0] ed, input logic eb,
                          input logic ez, input logic eo);
        int lat;
        lat = 0;
        start = 1'b1; a_in = a; b_in = b; bin_in = bi;
        @(posedge clk); #1 start = 1'b0;
        chk({tag, "_busy"}, 32'(busy_o[1]), 32'd1);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done_o[1]) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_diff"}, 32'(diff_o[1]), 32'(ed));
        chk({tag, "_bout"}, 32'(bout_o[1]), 32'(eb));
        chk({tag, "_zero"}, 32'(zero_o[1]), 32'(ez));
        chk({tag, "_ovf"}, 32'(ovf_o[1]), 32'(eo));
    endtask

    initial begin
        int n_exp [4];
        int w_of  [4];
        int ed, eb, ez, eo, ra, rb, rbi, done_cnt;
        int lat   [4];
        bit seen  [4];
        n_exp = '{16, 4, 1, 4};
        w_of  = '{16, 16, 16, 8};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o[1]), 32'd0);
        chk("rst_done", 32'(done_o[1]), 32'd0);
        chk("rst_diff", 32'(diff_o[1]), 32'd0);
        chk("rst_flags", {29'd0, bout_o[1], zero_o[1], ovf_o[1]}, 32'd0);
        rst = 1'b0;

        // Directed arithmetic
        run_op("basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("under",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("eq_bin", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("sovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        run_op("zero",   16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Handshake: ignored start while busy, accepted start in done cycle
        start = 1'b1; a_in = 16'h00FF; b_in = 16'h000F; bin_in = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF;
        @(posedge clk); #1 start = 1'b0;
        chk("hs_busy_ign", 32'(busy_o[1]), 32'd1);
        @(posedge clk); #1;
        chk("hs_done1", 32'(done_o[1]), 32'd1);
        chk("hs_diff1", 32'(diff_o[1]), 32'h00F0);
        start = 1'b1; a_in = 16'h0010; b_in = 16'h0001;
        @(posedge clk); #1 start = 1'b0;
        chk("hs_b2b_busy", 32'(busy_o[1]), 32'd1);
        chk("hs_done_pulse", 32'(done_o[1]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hs_hold", 32'(diff_o[1]), 32'h00F0);
        end
        @(posedge clk); #1;
        chk("hs_done2", 32'(done_o[1]), 32'd1);
        chk("hs_diff2", 32'(diff_o[1]), 32'h000F);

        // Reset during RUN aborts without a done pulse
        start = 1'b1; a_in = 16'h1234; b_in = 16'h0001;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", 32'(busy_o[1]), 32'd0);
        chk("abort_diff", 32'(diff_o[1]), 32'd0);
        chk("abort_flags", {29'd0, bout_o[1], zero_o[1], ovf_o[1]}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done_o[1]) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        run_op("after_abort", 16'h1234, 16'h0001, 1'b0, 16'h1233, 1'b0, 1'b0, 1'b0);

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        chk("rst_vs_start", 32'(busy_o[1]), 32'd0);
        repeat (16) @(posedge clk);
        #1;

        // Random sweep across all four configurations
        for (int op = 0; op < 1000; op++) begin
            ra  = int'($urandom_range(0, 16'hFFFF));
            rb  = ($urandom_range(0, 7) == 0) ? ra : int'($urandom_range(0, 16'hFFFF));
            rbi = int'($urandom_range(0, 1));
            start = 1'b1; a_in = 16'(ra); b_in = 16'(rb); bin_in = 1'(rbi);
            @(posedge clk); #1 start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                seen[i] = 1'b0;
                lat[i]  = 0;
            end
            for (int c = 1; c <= 20; c++) begin
                a_in = 16'($urandom); b_in = 16'($urandom); bin_in = 1'($urandom);
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    if (done_o[i] && !seen[i]) begin
                        seen[i] = 1'b1;
                        lat[i]  = c;
                        model(w_of[i], ra, rb, rbi, ed, eb, ez, eo);
                        chk($sformatf("rnd%0d_diff", i), 32'(diff_o[i]), 32'(ed));
                        chk($sformatf("rnd%0d_bout", i), 32'(bout_o[i]), 32'(eb));
                        chk($sformatf("rnd%0d_zero", i), 32'(zero_o[i]), 32'(ez));
                        chk($sformatf("rnd%0d_ovf", i), 32'(ovf_o[i]), 32'(eo));
                    end
                end
                if (seen[0] && seen[1] && seen[2] && seen[3]) break;
            end
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd%0d_latency", i), 32'(lat[i]), 32'(n_exp[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
